// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : types_pkg
// Brief    : Shared datapath types and the strategy schedule entry format.
// Revision : 1.0
// ============================================================================
package types_pkg;

  localparam int SIG_W = 8;

  typedef logic [SIG_W-1:0] input_signals_t;
  typedef logic [SIG_W-1:0] output_signals_t;
  typedef logic [SIG_W-1:0] parameters_t;

  typedef enum logic [1:0] {
    STRAT_NOP = 2'd0,
    STRAT_XOR = 2'd1,
    STRAT_INV = 2'd2
  } strategy_t;

  localparam int SCHED_DWELL_W = 16;

  typedef struct packed {
    strategy_t                strategy;
    parameters_t              par;
    logic [SCHED_DWELL_W-1:0] dwell;
  } sched_entry_t;

endpackage
`default_nettype wire

// File: rtl/strategy_inv.sv
`default_nettype none
// ============================================================================
// Module   : strategy_inv
// Brief    : Bitwise inversion strategy.
// Revision : 1.0
// ============================================================================
module strategy_inv
  import types_pkg::*;
(
  input  input_signals_t  in,
  output output_signals_t out
);

  assign out = ~in;

endmodule
`default_nettype wire

// File: rtl/strategy_mux.sv
`default_nettype none
// ============================================================================
// Module   : strategy_mux
// Brief    : Combinational selection among the nop/xor/inv strategies.
// Revision : 1.0
// ============================================================================
module strategy_mux
  import types_pkg::*;
(
  input  strategy_t       strategy,
  input  parameters_t     par,
  input  input_signals_t  in,
  output output_signals_t out
);

  output_signals_t w_nop_out;
  output_signals_t w_xor_out;
  output_signals_t w_inv_out;

  strategy_nop u_nop (.in(in), .out(w_nop_out));
  strategy_xor u_xor (.in(in), .par(par), .out(w_xor_out));
  strategy_inv u_inv (.in(in), .out(w_inv_out));

  // Unassigned code 3 falls through to passthrough.
  always_comb begin
    out = w_nop_out;
    case (strategy)
      STRAT_XOR: out = w_xor_out;
      STRAT_INV: out = w_inv_out;
      default:   out = w_nop_out;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/strategy_nop.sv
`default_nettype none
// ============================================================================
// Module   : strategy_nop
// Brief    : Passthrough strategy.
// Revision : 1.0
// ============================================================================
module strategy_nop
  import types_pkg::*;
(
  input  input_signals_t  in,
  output output_signals_t out
);

  assign out = in;

endmodule
`default_nettype wire

// File: rtl/strategy_xor.sv
`default_nettype none
// ============================================================================
// Module   : strategy_xor
// Brief    : XOR of the input with a parameter word.
// Revision : 1.0
// ============================================================================
module strategy_xor
  import types_pkg::*;
(
  input  input_signals_t  in,
  input  parameters_t     par,
  output output_signals_t out
);

  assign out = in ^ par;

endmodule
`default_nettype wire

// File: rtl/strategy_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : strategy_sequencer
// Brief    : Steps through a programmed table of strategies, each held for
//            its dwell; optional wrap-around enabled by STRATEGY_SEQ_LOOP_EN.
// Revision : 1.0
// ============================================================================
module strategy_sequencer
  import types_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  input_signals_t  in,
  output output_signals_t out,
  input  logic            cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  sched_entry_t    cfg_entry,
  input  logic [IDX_W:0]  num_entries,
  input  logic            loop,
  input  logic            start,
  input  logic            stop,
  output logic            busy,
  output logic            done,
  output logic [IDX_W-1:0] cur_idx
);

  localparam logic [0:0]     C_ST_IDLE = 1'b0;
  localparam logic [0:0]     C_ST_RUN  = 1'b1;
  localparam logic [IDX_W:0] C_DEPTH   = (IDX_W + 1)'(DEPTH);

  sched_entry_t             r_table [DEPTH];
  logic [0:0]               r_state;
  logic [0:0]               w_state_nxt;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W:0]           r_len;
  logic [SCHED_DWELL_W-1:0] r_dwell;
  strategy_t                r_act_strat;
  parameters_t              r_act_par;
  output_signals_t          r_out;
  logic                     r_done;

  logic                     w_load;
  logic                     w_sample;
  logic                     w_finish;
  logic [IDX_W-1:0]         w_load_idx;
  logic [IDX_W:0]           w_eff_len;
  logic                     w_last;
  logic                     w_loop_ok;
  sched_entry_t             w_entry;
  output_signals_t          w_mux_out;

  assign w_eff_len = (num_entries > C_DEPTH) ? C_DEPTH : num_entries;
  assign w_last    = ({1'b0, r_idx} == (r_len - 1'b1));
  // Table is read only here, so a same-cycle write to this index loads the old value.
  assign w_entry   = r_table[w_load_idx];

`ifdef STRATEGY_SEQ_LOOP_EN
  logic r_loop;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_loop <= 1'b0;
    end else if (w_sample) begin
      r_loop <= loop;
    end
  end

  assign w_loop_ok = r_loop;
`else
  logic w_unused_loop;

  assign w_unused_loop = loop;
  assign w_loop_ok     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_sample    = 1'b0;
    w_finish    = 1'b0;
    w_load_idx  = '0;
    case (r_state)
      C_ST_IDLE: begin
        if (start && (w_eff_len != '0)) begin
          w_state_nxt = C_ST_RUN;
          w_load      = 1'b1;
          w_sample    = 1'b1;
        end
      end
      C_ST_RUN: begin
        if (stop) begin
          w_state_nxt = C_ST_IDLE;
        end else if (r_dwell == '0) begin
          if (!w_last) begin
            w_load     = 1'b1;
            w_load_idx = r_idx + 1'b1;
          end else if (w_loop_ok && (w_eff_len != '0)) begin
            w_load   = 1'b1;
            w_sample = 1'b1;
          end else begin
            w_state_nxt = C_ST_IDLE;
            w_finish    = 1'b1;
          end
        end
      end
      default: w_state_nxt = C_ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state == C_ST_RUN);
    done    = r_done;
    cur_idx = r_idx;
    out     = r_out;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (cfg_we) begin
      r_table[cfg_addr] <= cfg_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_idx       <= '0;
      r_len       <= '0;
      r_dwell     <= '0;
      r_act_strat <= STRAT_NOP;
      r_act_par   <= '0;
      r_out       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_out  <= w_mux_out;
      r_done <= w_finish;
      if (w_sample) begin
        r_len <= w_eff_len;
      end
      if (w_load) begin
        r_idx       <= w_load_idx;
        r_dwell     <= w_entry.dwell;
        r_act_strat <= w_entry.strategy;
        r_act_par   <= w_entry.par;
      end else if (w_state_nxt == C_ST_IDLE) begin
        r_idx       <= '0;
        r_dwell     <= '0;
        r_act_strat <= STRAT_NOP;
        r_act_par   <= '0;
      end else begin
        r_dwell <= r_dwell - 1'b1;
      end
    end
  end

  strategy_mux u_mux (
    .strategy (r_act_strat),
    .par      (r_act_par),
    .in       (in),
    .out      (w_mux_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_strategy_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_strategy_sequencer
// Brief    : Directed scoreboard bench for strategy_sequencer.
// Revision : 1.0
// ============================================================================
module tb_strategy_sequencer;
  import types_pkg::*;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  input_signals_t   in_s = '0;
  output_signals_t  out_s;
  logic             cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_addr = '0;
  sched_entry_t     cfg_entry = '0;
  logic [IDX_W:0]   num_entries = '0;
  logic             loop_s = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] cur_idx;

  int               tests = 0;
  int               fails = 0;
  output_signals_t  exp_q[$];
  sched_entry_t     mdl_tab [DEPTH];

  always #5 clock = ~clock;

  strategy_sequencer #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .in          (in_s),
    .out         (out_s),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_entry   (cfg_entry),
    .num_entries (num_entries),
    .loop        (loop_s),
    .start       (start),
    .stop        (stop),
    .busy        (busy),
    .done        (done),
    .cur_idx     (cur_idx)
  );

  function automatic output_signals_t model(input input_signals_t i, input strategy_t s,
                                            input parameters_t p);
    case (s)
      STRAT_XOR: return i ^ p;
      STRAT_INV: return ~i;
      default:   return i;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a fresh input and queue the result expected on the next cycle.
  task automatic drive(input strategy_t s, input parameters_t p, input bit in_reset);
    in_s = input_signals_t'($urandom);
    exp_q.push_back(in_reset ? output_signals_t'(0) : model(in_s, s, p));
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) chk("out", 32'(out_s), 32'(exp_q.pop_front()));
  endtask

  task automatic run_cyc(input int idx, input sched_entry_t e);
    chk("busy_run", 32'(busy), 32'd1);
    chk("cur_idx", 32'(cur_idx), 32'(idx));
    chk("done_run", 32'(done), 32'd0);
    drive(e.strategy, e.par, 1'b0);
    tick();
  endtask

  task automatic run_pass(input int len);
    for (int i = 0; i < len; i++) begin
      for (int d = 0; d <= int'(mdl_tab[i].dwell); d++) begin
        run_cyc(i, mdl_tab[i]);
      end
    end
  endtask

  task automatic do_start(input int n);
    num_entries = (IDX_W + 1)'(n);
    start = 1'b1;
    drive(STRAT_NOP, '0, 1'b0);
    tick();
    start = 1'b0;
  endtask

  task automatic end_chk;
    chk("busy_end", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    drive(STRAT_NOP, '0, 1'b0);
    tick();
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic wr(input int addr, input sched_entry_t e);
    cfg_we    = 1'b1;
    cfg_addr  = IDX_W'(addr);
    cfg_entry = e;
    drive(STRAT_NOP, '0, 1'b0);
    tick();
    cfg_we = 1'b0;
    mdl_tab[addr] = e;
  endtask

  initial begin
    sched_entry_t old_e;
    sched_entry_t new_e;
    for (int i = 0; i < DEPTH; i++) mdl_tab[i] = '0;

    // Reset with toggling input
    repeat (2) begin
      drive(STRAT_NOP, '0, 1'b1);
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_idx", 32'(cur_idx), 32'd0);
    end
    reset = 1'b1;
    repeat (3) begin
      drive(STRAT_NOP, '0, 1'b0);
      tick();
    end

    // Basic three-entry schedule
    wr(0, '{strategy: STRAT_XOR, par: 8'hff, dwell: 16'd2});
    wr(1, '{strategy: STRAT_INV, par: 8'h00, dwell: 16'd0});
    wr(2, '{strategy: STRAT_NOP, par: 8'h00, dwell: 16'd1});
    do_start(3);
    run_pass(3);
    end_chk();

    // Stop in second cycle of entry 0
    do_start(3);
    run_cyc(0, mdl_tab[0]);
    stop = 1'b1;
    run_cyc(0, mdl_tab[0]);
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    drive(STRAT_NOP, '0, 1'b0);
    tick();
    chk("stop_done2", 32'(done), 32'd0);

    // Loop request
    loop_s = 1'b1;
    do_start(3);
`ifdef STRATEGY_SEQ_LOOP_EN
    run_pass(3);
    run_pass(3);
    stop = 1'b1;
    run_cyc(0, mdl_tab[0]);
    stop = 1'b0;
    chk("loop_busy", 32'(busy), 32'd0);
    chk("loop_done", 32'(done), 32'd0);
    drive(STRAT_NOP, '0, 1'b0);
    tick();
`else
    run_pass(3);
    end_chk();
`endif
    loop_s = 1'b0;

    // Zero-length schedule is ignored
    do_start(0);
    chk("zero_busy", 32'(busy), 32'd0);
    drive(STRAT_NOP, '0, 1'b0);
    tick();
    chk("zero_busy2", 32'(busy), 32'd0);
    chk("zero_done", 32'(done), 32'd0);

    // Over-long length clamps to DEPTH
    for (int i = 3; i < DEPTH; i++) begin
      wr(i, '{strategy: STRAT_XOR, par: parameters_t'(i * 17), dwell: 16'd0});
    end
    do_start(12);
    run_pass(DEPTH);
    end_chk();

    // Rewrite entry 1 while entry 0 is active
    do_start(3);
    cfg_we    = 1'b1;
    cfg_addr  = 3'd1;
    cfg_entry = '{strategy: STRAT_XOR, par: 8'h55, dwell: 16'd0};
    mdl_tab[1] = cfg_entry;
    run_cyc(0, mdl_tab[0]);
    cfg_we = 1'b0;
    run_cyc(0, mdl_tab[0]);
    run_cyc(0, mdl_tab[0]);
    run_cyc(1, mdl_tab[1]);
    run_cyc(2, mdl_tab[2]);
    run_cyc(2, mdl_tab[2]);
    end_chk();

    // Write entry 0 during its own load cycle: old contents apply this run
    old_e = mdl_tab[0];
    new_e = '{strategy: STRAT_INV, par: 8'h3c, dwell: 16'd0};
    num_entries = 4'd3;
    start     = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = 3'd0;
    cfg_entry = new_e;
    drive(STRAT_NOP, '0, 1'b0);
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    for (int d = 0; d <= int'(old_e.dwell); d++) run_cyc(0, old_e);
    mdl_tab[0] = new_e;
    run_cyc(1, mdl_tab[1]);
    run_cyc(2, mdl_tab[2]);
    run_cyc(2, mdl_tab[2]);
    end_chk();
    do_start(3);
    run_pass(3);
    end_chk();

    // Reset mid-run clears state and table
    do_start(3);
    run_cyc(0, mdl_tab[0]);
    reset = 1'b0;
    drive(STRAT_NOP, '0, 1'b1);
    tick();
    reset = 1'b1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_idx", 32'(cur_idx), 32'd0);
    for (int i = 0; i < DEPTH; i++) mdl_tab[i] = '0;
    do_start(3);
    run_pass(3);
    end_chk();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
